// File: rtl/spi_adc_pkg.sv
// ============================================================================
// spi_adc_pkg : shared types for the SPI ADC responder
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2
  } state_t;

  localparam int FRAME_BITS_DEF = 16;

  typedef logic signed [15:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/spi_in_sync.sv
// ============================================================================
// spi_in_sync : multi-flop synchronizer with level, rise and fall outputs
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level_o = r_sync[SYNC_STAGES-1];
  assign rise_o  = level_o & ~r_prev;
  assign fall_o  = ~level_o & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_adc_responder.sv
// ============================================================================
// spi_adc_responder : SPI ADC stand-in serving streamed 16-bit samples on MISO
// Revision          : 1.0
// ============================================================================
`default_nettype none

module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int T_CONV      = 35,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cnv_i,
  input  logic        spi_clk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        underrun_o,
  output logic [15:0] frame_count_o,
  output logic [7:0]  err_count_o
);

  localparam int CNT_W = $clog2(T_CONV + 1);
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  logic w_cnv_level, w_cnv_rise, w_cnv_fall;
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cnv_sync (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(cnv_i),
    .level_o(w_cnv_level), .rise_o(w_cnv_rise), .fall_o(w_cnv_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_clk_i),
    .level_o(w_sclk_level), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_mosi_i),
    .level_o(w_mosi_level), .rise_o(w_mosi_rise), .fall_o(w_mosi_fall)
  );

  logic w_unused;
  assign w_unused = w_cnv_level ^ w_sclk_level ^ w_sclk_rise ^ w_mosi_rise ^ w_mosi_fall;

  state_t                r_state;
  sample_t               r_hold;
  sample_t               r_last;
  logic                  r_full;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bit;
  logic                  r_mosi_err;

  logic w_transfer;
  logic w_full_next;
  logic w_err_inc;

  // A transfer in the latch cycle only happens when empty, so the new sample stays held.
  assign w_transfer  = sample_valid_i & sample_ready_o;
  assign w_full_next = w_transfer | (r_full & ~w_cnv_rise);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hold         <= '0;
      r_full         <= 1'b0;
      sample_ready_o <= 1'b1;
    end else begin
      if (w_transfer) begin
        r_hold <= sample_i;
      end
      r_full         <= w_full_next;
      sample_ready_o <= ~w_full_next;
    end
  end

  // Event priority: cnv rise > cnv fall > sclk fall; at most one error per cycle.
  always_comb begin
    w_err_inc = 1'b0;
    if (w_cnv_rise) begin
      w_err_inc = (r_state == ST_SHIFT);
    end else if (w_cnv_fall) begin
      w_err_inc = (r_state == ST_CONVERT) && (r_cnt < CNT_W'(T_CONV));
    end else if (w_sclk_fall) begin
      w_err_inc = (r_state == ST_SHIFT) && !w_mosi_level && !r_mosi_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_last        <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_mosi_err    <= 1'b0;
      spi_miso_o    <= 1'b0;
      busy_o        <= 1'b0;
      frame_done_o  <= 1'b0;
      underrun_o    <= 1'b0;
      frame_count_o <= '0;
      err_count_o   <= '0;
    end else begin
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;

      if (w_err_inc && (err_count_o != 8'hFF)) begin
        err_count_o <= err_count_o + 8'd1;
      end

      if (w_cnv_rise) begin
        r_state    <= ST_CONVERT;
        busy_o     <= 1'b1;
        spi_miso_o <= 1'b0;
        r_cnt      <= '0;
        r_mosi_err <= 1'b0;
        if (r_full) begin
          r_shift <= FRAME_BITS'(r_hold);
          r_last  <= r_hold;
        end else begin
          r_shift    <= FRAME_BITS'(r_last);
          underrun_o <= 1'b1;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            spi_miso_o <= 1'b0;
          end
          ST_CONVERT: begin
            if (r_cnt != CNT_W'(T_CONV)) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_cnv_fall) begin
              r_state    <= ST_SHIFT;
              r_bit      <= '0;
              spi_miso_o <= r_shift[FRAME_BITS-1];
            end
          end
          ST_SHIFT: begin
            if (w_sclk_fall) begin
              if (!w_mosi_level) begin
                r_mosi_err <= 1'b1;
              end
              r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
              if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
                r_state       <= ST_IDLE;
                busy_o        <= 1'b0;
                spi_miso_o    <= 1'b0;
                frame_done_o  <= 1'b1;
                frame_count_o <= frame_count_o + 16'd1;
              end else begin
                r_bit      <= r_bit + BIT_W'(1);
                spi_miso_o <= r_shift[FRAME_BITS-2];
              end
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            busy_o     <= 1'b0;
            spi_miso_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
